// File: rtl/decode_pipe_if.sv
// decode_pipe_if: bundles every non-clock/reset signal of decode_pipe.
//   Fetch side     : flush, in_valid/in_ready, in_pc, in_command
//   Register file  : reg1/reg2, fmode1/fmode2 (addresses), reg_out1/reg_out2 (data)
//   Forwarding     : fwd_valid, fwd_no, fwd_fmode, fwd_data (FWD_PORTS channels)
//   Load hazard    : hz_valid, hz_no, hz_fmode
//   Execute side   : out_valid/out_ready and the registered decoded fields
// Modport slave is the decode stage; master is its surrounding environment.
interface decode_pipe_if #(
    parameter int unsigned XLEN      = 32,
    parameter int unsigned FWD_PORTS = 2
);
    logic                      flush;
    logic                      in_valid;
    logic                      in_ready;
    logic [XLEN-1:0]           in_pc;
    logic [31:0]               in_command;

    logic [4:0]                reg1;
    logic [4:0]                reg2;
    logic                      fmode1;
    logic                      fmode2;
    logic [XLEN-1:0]           reg_out1;
    logic [XLEN-1:0]           reg_out2;

    logic [FWD_PORTS-1:0]      fwd_valid;
    logic [5*FWD_PORTS-1:0]    fwd_no;
    logic [FWD_PORTS-1:0]      fwd_fmode;
    logic [XLEN*FWD_PORTS-1:0] fwd_data;

    logic                      hz_valid;
    logic [4:0]                hz_no;
    logic                      hz_fmode;

    logic                      out_valid;
    logic                      out_ready;
    logic [5:0]                opecode;
    logic [15:0]               offset;
    logic [XLEN-1:0]           pc_out;
    logic [XLEN-1:0]           rs;
    logic [XLEN-1:0]           rt;
    logic [4:0]                rd_no;
    logic [4:0]                rs_no;
    logic [4:0]                rt_no;
    logic                      fmode1_reg;
    logic                      fmode2_reg;

    modport slave (
        input  flush, in_valid, in_pc, in_command,
        output in_ready,
        output reg1, reg2, fmode1, fmode2,
        input  reg_out1, reg_out2,
        input  fwd_valid, fwd_no, fwd_fmode, fwd_data,
        input  hz_valid, hz_no, hz_fmode,
        input  out_ready,
        output out_valid, opecode, offset, pc_out, rs, rt,
        output rd_no, rs_no, rt_no, fmode1_reg, fmode2_reg
    );

    modport master (
        output flush, in_valid, in_pc, in_command,
        input  in_ready,
        input  reg1, reg2, fmode1, fmode2,
        output reg_out1, reg_out2,
        output fwd_valid, fwd_no, fwd_fmode, fwd_data,
        output hz_valid, hz_no, hz_fmode,
        output out_ready,
        input  out_valid, opecode, offset, pc_out, rs, rt,
        input  rd_no, rs_no, rt_no, fmode1_reg, fmode2_reg
    );
endinterface

// File: rtl/decode_pipe.sv
// decode_pipe: registered decode stage between fetch and execute.
//   Splits the instruction word into fields, reads both sources from the
//   integer or FP register file, resolves RAW hazards by forwarding from
//   FWD_PORTS later stages (channel 0 = youngest, highest priority) or by
//   stalling on a pending load, and presents the result in a valid/ready
//   output register with flush.
// Ports:
//   clk  - clock
//   rst  - synchronous, active-high reset
//   bus  - decode_pipe_if.slave (fetch, register file, forwarding, hazard,
//          execute handshake and decoded fields)
module decode_pipe #(
    parameter int unsigned XLEN      = 32,
    parameter int unsigned FWD_PORTS = 2,
    parameter bit          ZERO_REG  = 1'b1
) (
    input  logic          clk,
    input  logic          rst,
    decode_pipe_if.slave  bus
);

    // ------------------------------------------------------------------
    // Combinational field decode of the incoming instruction
    // ------------------------------------------------------------------
    logic [31:0] cmd;
    logic [4:0]  src1_no;
    logic [4:0]  src2_no;
    logic        src_fmode;

    always_comb begin
        cmd       = bus.in_command;
        src1_no   = cmd[25:21];
        src2_no   = cmd[20:16];
        src_fmode = (cmd[31:30] == 2'b11);
    end

    assign bus.reg1   = src1_no;
    assign bus.reg2   = src2_no;
    assign bus.fmode1 = src_fmode;
    assign bus.fmode2 = src_fmode;

    // Integer r0 is hard-wired to zero: never forwarded, never stalls.
    function automatic logic is_zero_reg(input logic [4:0] no, input logic fm);
        return ZERO_REG && !fm && (no == 5'd0);
    endfunction

    // Source value: zero register, then lowest-index matching forward
    // channel, then the supplied default.
    function automatic logic [XLEN-1:0] select_src(
        input logic [4:0]                no,
        input logic                      fm,
        input logic [XLEN-1:0]           dflt,
        input logic [FWD_PORTS-1:0]      fv,
        input logic [5*FWD_PORTS-1:0]    fn,
        input logic [FWD_PORTS-1:0]      ff,
        input logic [XLEN*FWD_PORTS-1:0] fd
    );
        logic [XLEN-1:0] val;
        logic            hit;
        val = dflt;
        hit = 1'b0;
        if (is_zero_reg(no, fm)) begin
            val = '0;
        end else begin
            for (int unsigned i = 0; i < FWD_PORTS; i++) begin
                if (!hit && fv[i] && (fn[5*i +: 5] == no) && (ff[i] == fm)) begin
                    val = fd[XLEN*i +: XLEN];
                    hit = 1'b1;
                end
            end
        end
        return val;
    endfunction

    function automatic logic load_pending(
        input logic       hv,
        input logic [4:0] hn,
        input logic       hf,
        input logic [4:0] no,
        input logic       fm
    );
        return hv && (hn == no) && (hf == fm) && !is_zero_reg(no, fm);
    endfunction

    // ------------------------------------------------------------------
    // Output pipeline register
    // ------------------------------------------------------------------
    logic            out_valid_q,  out_valid_d;
    logic [5:0]      opecode_q,    opecode_d;
    logic [15:0]     offset_q,     offset_d;
    logic [XLEN-1:0] pc_out_q,     pc_out_d;
    logic [XLEN-1:0] rs_q,         rs_d;
    logic [XLEN-1:0] rt_q,         rt_d;
    logic [4:0]      rd_no_q,      rd_no_d;
    logic [4:0]      rs_no_q,      rs_no_d;
    logic [4:0]      rt_no_q,      rt_no_d;
    logic            fmode1_reg_q, fmode1_reg_d;
    logic            fmode2_reg_q, fmode2_reg_d;

    logic            advance;
    logic            stall;
    logic            in_ready;
    logic            accept;
    logic [XLEN-1:0] src1_val;
    logic [XLEN-1:0] src2_val;

    always_comb begin
        advance  = !out_valid_q || bus.out_ready;
        stall    = load_pending(bus.hz_valid, bus.hz_no, bus.hz_fmode, src1_no, src_fmode)
                || load_pending(bus.hz_valid, bus.hz_no, bus.hz_fmode, src2_no, src_fmode);
        // Flush always consumes the incoming word, even when stalled or held.
        in_ready = bus.flush || (advance && !stall);
        accept   = bus.in_valid && in_ready && !bus.flush;

        src1_val = select_src(src1_no, src_fmode, bus.reg_out1, bus.fwd_valid,
                              bus.fwd_no, bus.fwd_fmode, bus.fwd_data);
        src2_val = select_src(src2_no, src_fmode, bus.reg_out2, bus.fwd_valid,
                              bus.fwd_no, bus.fwd_fmode, bus.fwd_data);

        out_valid_d  = out_valid_q;
        opecode_d    = opecode_q;
        offset_d     = offset_q;
        pc_out_d     = pc_out_q;
        rs_d         = rs_q;
        rt_d         = rt_q;
        rd_no_d      = rd_no_q;
        rs_no_d      = rs_no_q;
        rt_no_d      = rt_no_q;
        fmode1_reg_d = fmode1_reg_q;
        fmode2_reg_d = fmode2_reg_q;

        if (bus.flush) begin
            out_valid_d = 1'b0;
        end else if (accept) begin
            out_valid_d  = 1'b1;
            opecode_d    = cmd[31:26];
            offset_d     = cmd[15:0];
            pc_out_d     = bus.in_pc;
            rs_d         = src1_val;
            rt_d         = src2_val;
            rd_no_d      = cmd[15:11];
            rs_no_d      = src1_no;
            rt_no_d      = src2_no;
            fmode1_reg_d = src_fmode;
            fmode2_reg_d = src_fmode;
        end else if (advance) begin
            out_valid_d = 1'b0;
        end else begin
            // Held by execute: keep operands fresh from results that land
            // while we wait, matched against the held source registers.
            rs_d = select_src(rs_no_q, fmode1_reg_q, rs_q, bus.fwd_valid,
                              bus.fwd_no, bus.fwd_fmode, bus.fwd_data);
            rt_d = select_src(rt_no_q, fmode2_reg_q, rt_q, bus.fwd_valid,
                              bus.fwd_no, bus.fwd_fmode, bus.fwd_data);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q  <= 1'b0;
            opecode_q    <= '0;
            offset_q     <= '0;
            pc_out_q     <= '0;
            rs_q         <= '0;
            rt_q         <= '0;
            rd_no_q      <= '0;
            rs_no_q      <= '0;
            rt_no_q      <= '0;
            fmode1_reg_q <= 1'b0;
            fmode2_reg_q <= 1'b0;
        end else begin
            out_valid_q  <= out_valid_d;
            opecode_q    <= opecode_d;
            offset_q     <= offset_d;
            pc_out_q     <= pc_out_d;
            rs_q         <= rs_d;
            rt_q         <= rt_d;
            rd_no_q      <= rd_no_d;
            rs_no_q      <= rs_no_d;
            rt_no_q      <= rt_no_d;
            fmode1_reg_q <= fmode1_reg_d;
            fmode2_reg_q <= fmode2_reg_d;
        end
    end

    assign bus.in_ready   = in_ready;
    assign bus.out_valid  = out_valid_q;
    assign bus.opecode    = opecode_q;
    assign bus.offset     = offset_q;
    assign bus.pc_out     = pc_out_q;
    assign bus.rs         = rs_q;
    assign bus.rt         = rt_q;
    assign bus.rd_no      = rd_no_q;
    assign bus.rs_no      = rs_no_q;
    assign bus.rt_no      = rt_no_q;
    assign bus.fmode1_reg = fmode1_reg_q;
    assign bus.fmode2_reg = fmode2_reg_q;

endmodule

// File: doc/decode_pipe.md
# decode_pipe

Parametrised, registered successor to the decode stage. It splits an instruction word into fields and reads both source registers from the integer or FP file. It resolves RAW hazards by forwarding from up to `FWD_PORTS` later stages, or by stalling on a pending load. Results are held in an output pipeline register with valid/ready flow control and flush. It sits between fetch and execute.

## Interface
- `XLEN`, 32: datapath / PC width.
- `FWD_PORTS`, 2: number of forwarding channels; index 0 is the youngest producer and has highest priority.
- `ZERO_REG`, 1: when 1, integer register 0 reads as 0 and is never forwarded or hazarded.

- `clk`  in  1  clock.
- `rst`  in  1  synchronous, active-high reset.
- `flush`  in  1  kill the in-flight and incoming instruction.
- `in_valid` / `in_ready`  in / out  1  fetch handshake.
- `in_pc`  in  XLEN  PC of the instruction.
- `in_command`  in  32  instruction word.
- `reg1`, `reg2`  out  5  register-file read addresses; combinational from `in_command`.
- `fmode1`, `fmode2`  out  1  file select for each read: 1 = FP.
- `reg_out1`, `reg_out2`  in  XLEN  register-file read data, same cycle.
- `fwd_valid`  in  FWD_PORTS  forwarding channel i carries a result.
- `fwd_no`  in  5*FWD_PORTS  destination register of channel i.
- `fwd_fmode`  in  FWD_PORTS  destination file of channel i.
- `fwd_data`  in  XLEN*FWD_PORTS  result of channel i.
- `hz_valid`, `hz_no` (5), `hz_fmode`  in  pending load whose data is not yet forwardable.
- `out_valid` / `out_ready`  out / in  1  execute handshake.
- `opecode` (6), `offset` (16), `pc_out` (XLEN), `rs`, `rt` (XLEN), `rd_no`, `rs_no`, `rt_no` (5), `fmode1_reg`, `fmode2_reg` (1)  out  registered decoded instruction.

## Operation
- Field decode:
  - opecode = cmd[31:26], rs_no = cmd[25:21], rt_no = cmd[20:16], rd_no = cmd[15:11], offset = cmd[15:0].
  - fmode1 = fmode2 = (cmd[31:30] == 2'b11).
- Source select, per operand, in priority order:
  1. If ZERO_REG and fmode = 0 and reg = 0: value 0.
  2. Otherwise, the lowest-index channel i with fwd_valid[i], fwd_no[i] == reg and fwd_fmode[i] == fmode: fwd_data[i].
  3. Otherwise: reg_out.
- Stall: `hz_valid`, `hz_no` == a source reg, `hz_fmode` == that source's fmode, and the source is not the int r0 exemption.
- `advance` = !out_valid | out_ready.
- `in_ready` = flush | (advance & !stall).
- On accept (in_valid & in_ready & !flush): load all output fields and set out_valid = 1.
- When advance & !(in_valid & in_ready), out_valid clears (bubble).
- Hold: while out_valid & !out_ready, all fields keep their values. Exception: on each cycle, rs/rt are overwritten by any matching fwd channel (same priority, matched against the held rs_no/fmode1_reg and rt_no/fmode2_reg). This keeps operands fresh while execute is blocked.
- Flush: the next-cycle out_valid = 0, the incoming instruction is consumed and discarded, and flush overrides both stall and hold.

## Timing
- Latency 1 cycle from accept to out_valid.
- Throughput 1 per cycle with no stall.
- Reset: out_valid = 0, every registered output = 0, and in_ready follows the combinational rule from the first cycle after reset.
- Reset asserted mid-hold discards the held instruction.
- A stall with out_ready = 1 produces exactly one bubble per stalled cycle.
- Stall and hold together: the output holds and in_ready = 0.
- Simultaneous flush and accept: the instruction is dropped and out_valid = 0.
- Duplicate forwarding matches: the lowest index wins.
- Output fields are don't-care while out_valid = 0, but remain registered and change only on accept or reset (except the hold-forwarding update of rs/rt).

## Test plan
- Back-to-back: 3 instructions, out_ready = 1, regfile returns 0x11/0x22 → outputs appear one per cycle, one cycle after accept, with correct field splits (e.g. cmd 0x8C43000C → opecode 0x23, rs_no 2, rt_no 3, offset 0x000C).
- Forward priority: fwd_valid = 2'b11, both channels on reg 2 (int), data 0xAAAA/0xBBBB → rs = 0xAAAA. FP source with the same number but int fwd → reg_out used. Int r0 → 0.
- Load-use: hz on reg 3 int for 2 cycles → in_ready = 0, two bubbles, then accept with rt taken from forwarding.
- Backpressure: out_ready = 0 for 3 cycles, fwd on held rs_no with 0x1234 in cycle 2 → fields stable, rs becomes 0x1234, and is released when out_ready = 1.
- Flush during hold plus a new in_valid → out_valid = 0 next cycle, and the new instruction is never emitted.
- Reset pulsed mid-stream → all outputs 0 and out_valid = 0 the following cycle, with normal operation resuming.
